// File: rtl/ms_tick_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel ms tick bank.
package ms_tick_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Clocks per base tick; zero when the tick rate is unusable.
    function automatic int calc_presc(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

    // Width of a counter that runs 0..presc-1.
    function automatic int presc_width(input int presc);
        return (presc < 2) ? 1 : $clog2(presc);
    endfunction

    // The prescaler needs an exact integer ratio and at least two clocks per tick.
    function automatic bit params_ok(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 1'b0;
        end
        return ((clk_hz % tick_hz) == 0) && ((clk_hz / tick_hz) >= 2);
    endfunction

endpackage

// File: rtl/ms_tick_channel.sv
// One tick-divider channel: counts base ticks and strobes pulse every div ticks.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  CH_IDLE | channel stopped, counter cleared, waiting for start
//  CH_RUN  | counting base ticks toward the latched divide value
module ms_tick_channel
    import ms_tick_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             oneshot_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             pulse_o,
    output logic             running_o,
    output logic             done_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    ch_state_t        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] last_q, last_d;   // latched divide value minus one
    logic             os_q, os_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;
    logic             terminal;

    // A tick that lands on the last count of the period completes it.
    assign terminal = tick_i && (cnt_q == last_q);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            os_q    <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            os_q    <= os_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    // Next state: start always wins, then stop, then one-shot completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_IDLE: begin
                if (start_i) begin
                    state_d = CH_RUN;
                end
            end
            CH_RUN: begin
                if (start_i) begin
                    state_d = CH_RUN;
                end else if (stop_i) begin
                    state_d = CH_IDLE;
                end else if (terminal && os_q) begin
                    state_d = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    // Counter, latched configuration and strobes; a divide of zero acts as one.
    always_comb begin
        cnt_d     = cnt_q;
        last_d    = last_q;
        os_d      = os_q;
        pulse_d   = 1'b0;
        done_d    = 1'b0;
        running_o = (state_q == CH_RUN);
        if (start_i) begin
            cnt_d  = '0;
            last_d = (div_i == '0) ? '0 : div_i - ONE;
            os_d   = oneshot_i;
        end else if (state_q == CH_RUN) begin
            if (stop_i) begin
                cnt_d = '0;
            end else if (terminal) begin
                cnt_d   = '0;
                pulse_d = 1'b1;
                done_d  = os_q;
            end else if (tick_i) begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    assign pulse_o = pulse_q;
    assign done_o  = done_q;

endmodule

// File: rtl/ms_tick_bank.sv
// Shared base-tick prescaler feeding NUM_CH independent tick-divider channels.
module ms_tick_bank
    import ms_tick_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int TICK_FREQ_HZ = 1_000,
    parameter int NUM_CH       = 4,
    parameter int DIV_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       oneshot,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    output logic                    tick,
    output logic [NUM_CH-1:0]       pulse,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       done
);

    localparam int              PRESC      = calc_presc(CLK_FREQ_HZ, TICK_FREQ_HZ);
    localparam int              PW         = presc_width(PRESC);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);

    if (!params_ok(CLK_FREQ_HZ, TICK_FREQ_HZ)) begin : g_param_check
        $error("ms_tick_bank: CLK_FREQ_HZ must be an exact multiple of TICK_FREQ_HZ giving PRESC >= 2");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;

    // Free-running prescaler; the tick is registered one clock after the last count.
    always_comb begin
        tick_d  = (presc_q == PRESC_LAST);
        presc_d = tick_d ? '0 : presc_q + PW'(1);
    end

    // Prescaler registers; never re-phased by channel activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ms_tick_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick_q),
            .start_i   (start[i]),
            .stop_i    (stop[i]),
            .oneshot_i (oneshot[i]),
            .div_i     (div_val[i*DIV_W +: DIV_W]),
            .pulse_o   (pulse[i]),
            .running_o (running[i]),
            .done_o    (done[i])
        );
    end

endmodule

// File: tb/tb_ms_tick_bank.sv
// Self-checking bench for ms_tick_bank with PRESC=5, two 4-bit channels.
module tb_ms_tick_bank;

    localparam int NCH = 2;
    localparam int DW  = 4;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic [NCH-1:0]    start   = '0;
    logic [NCH-1:0]    stop    = '0;
    logic [NCH-1:0]    oneshot = '0;
    logic [NCH*DW-1:0] div_val = '0;
    logic              tick;
    logic [NCH-1:0]    pulse;
    logic [NCH-1:0]    running;
    logic [NCH-1:0]    done;

    int checks   = 0;
    int failures = 0;

    // Reference model: edges since reset, ticks still owed per channel.
    int           n_m;
    bit           exp_tick;
    bit [NCH-1:0] exp_pulse;
    bit [NCH-1:0] exp_done;
    bit [NCH-1:0] m_run;
    int           m_left [NCH];
    int           m_div  [NCH];
    bit           m_os   [NCH];
    bit           tick_seen_m;

    ms_tick_bank #(
        .CLK_FREQ_HZ  (10),
        .TICK_FREQ_HZ (2),
        .NUM_CH       (NCH),
        .DIV_W        (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .oneshot (oneshot),
        .div_val (div_val),
        .tick    (tick),
        .pulse   (pulse),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_m       = 0;
            exp_tick  = 1'b0;
            exp_pulse = '0;
            exp_done  = '0;
            m_run     = '0;
            for (int c = 0; c < NCH; c++) begin
                m_left[c] = 0;
                m_div[c]  = 1;
                m_os[c]   = 1'b0;
            end
        end else begin
            tick_seen_m = exp_tick;
            n_m         = n_m + 1;
            exp_tick    = ((n_m % 5) == 0);
            exp_pulse   = '0;
            exp_done    = '0;
            for (int c = 0; c < NCH; c++) begin
                if (start[c]) begin
                    m_run[c]  = 1'b1;
                    m_div[c]  = (div_val[c*DW +: DW] == 0) ? 1 : int'(div_val[c*DW +: DW]);
                    m_left[c] = m_div[c];
                    m_os[c]   = oneshot[c];
                end else if (m_run[c]) begin
                    if (stop[c]) begin
                        m_run[c] = 1'b0;
                    end else if (tick_seen_m) begin
                        m_left[c] = m_left[c] - 1;
                        if (m_left[c] == 0) begin
                            exp_pulse[c] = 1'b1;
                            if (m_os[c]) begin
                                exp_done[c] = 1'b1;
                                m_run[c]    = 1'b0;
                            end else begin
                                m_left[c] = m_div[c];
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic logic [6:0] obs_vec();
        return {tick, pulse, running, done};
    endfunction

    function automatic logic [6:0] exp_vec();
        return {exp_tick, exp_pulse, m_run, exp_done};
    endfunction

    task automatic test_reset();
        int first;
        int nt;
        first = -1;
        nt    = 0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_vec() !== 7'd0) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", obs_vec(), 7'd0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (tick) begin
                nt++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (first !== 5) begin
            failures++;
            $display("FAIL first_tick got=%0d exp=5", first);
        end
        checks++;
        if (nt !== 4) begin
            failures++;
            $display("FAIL tick_count got=%0d exp=4", nt);
        end
    endtask

    task automatic test_periodic();
        int last;
        int npost;
        last  = -1;
        npost = 0;
        @(negedge clk);
        start = 2'b01; oneshot = 2'b00; div_val[3:0] = 4'd3;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL periodic_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (k == 0) begin
                start = '0;
                checks++;
                if (running[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL periodic_running got=%b exp=1", running[0]);
                end
            end
            if (pulse[0]) begin
                if (last >= 0) begin
                    checks++;
                    if (k - last !== 15) begin
                        failures++;
                        $display("FAIL periodic_period got=%0d exp=15", k - last);
                    end
                end
                last = k;
            end
        end
        checks++;
        if (last < 0) begin
            failures++;
            $display("FAIL periodic_seen got=none exp=pulse");
        end
        stop = 2'b01;
        @(negedge clk);
        checks++;
        if (running[0] !== 1'b0) begin
            failures++;
            $display("FAIL stop_running got=%b exp=0", running[0]);
        end
        stop = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stopped_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (pulse[0]) npost++;
        end
        checks++;
        if (npost !== 0) begin
            failures++;
            $display("FAIL stopped_pulses got=%0d exp=0", npost);
        end
    endtask

    task automatic test_oneshot();
        int ntk, t2, kp, np, nco;
        ntk = 0; t2 = -1; kp = -1; np = 0; nco = 0;
        @(negedge clk);
        start = 2'b10; oneshot = 2'b10; div_val[7:4] = 4'd2;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL oneshot_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (k == 0) begin
                start   = '0;
                oneshot = '0;
            end
            if (pulse[1]) begin
                np++;
                kp = k;
                if (done[1] && !running[1]) nco++;
            end
            if (tick) begin
                ntk++;
                if (ntk == 2) t2 = k;
            end
        end
        checks++;
        if (np !== 1) begin
            failures++;
            $display("FAIL oneshot_count got=%0d exp=1", np);
        end
        checks++;
        if (nco !== 1) begin
            failures++;
            $display("FAIL oneshot_done_align got=%0d exp=1", nco);
        end
        checks++;
        if (kp !== t2 + 1) begin
            failures++;
            $display("FAIL oneshot_latency got=%0d exp=%0d", kp, t2 + 1);
        end
        checks++;
        if (running[1] !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_idle got=%b exp=0", running[1]);
        end
    endtask

    task automatic test_restart();
        logic [3:0] dv;
        int t1, last, np;
        @(negedge clk);
        start = 2'b01; oneshot = 2'b00; div_val[3:0] = 4'd4;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL restart_pre_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (k == 0) start = '0;
        end
        for (int r = 0; r < 2; r++) begin
            dv = (r == 0) ? 4'd1 : 4'd0;
            start = 2'b01; stop = 2'b01; div_val[3:0] = dv;
            t1 = -1; last = -1; np = 0;
            for (int k = 0; k < 26; k++) begin
                @(negedge clk);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL restart_model div=%0d k=%0d got=%b exp=%b", dv, k, obs_vec(), exp_vec());
                end
                if (k == 0) begin
                    start = '0;
                    stop  = '0;
                    checks++;
                    if (running[0] !== 1'b1) begin
                        failures++;
                        $display("FAIL restart_running div=%0d got=%b exp=1", dv, running[0]);
                    end
                end
                if (pulse[0]) begin
                    np++;
                    checks++;
                    if (last < 0) begin
                        if (k !== t1 + 1) begin
                            failures++;
                            $display("FAIL restart_first div=%0d got=%0d exp=%0d", dv, k, t1 + 1);
                        end
                    end else if (k - last !== 5) begin
                        failures++;
                        $display("FAIL restart_period div=%0d got=%0d exp=5", dv, k - last);
                    end
                    last = k;
                end
                if (tick && t1 < 0) t1 = k;
            end
            checks++;
            if (np < 4) begin
                failures++;
                $display("FAIL restart_count div=%0d got=%0d exp=4+", dv, np);
            end
        end
    endtask

    task automatic test_stop_terminal();
        int found;
        found = -1;
        @(negedge clk);
        start = 2'b01; oneshot = 2'b00; div_val[3:0] = 4'd2;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stopterm_pre_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (k == 0) start = '0;
            if (m_run[0] && m_left[0] == 1 && exp_tick) begin
                stop  = 2'b01;
                found = k;
                break;
            end
        end
        checks++;
        if (found < 0) begin
            failures++;
            $display("FAIL stopterm_window got=none exp=terminal_tick");
        end
        @(negedge clk);
        stop = '0;
        checks++;
        if (pulse[0] !== 1'b0) begin
            failures++;
            $display("FAIL stopterm_pulse got=%b exp=0", pulse[0]);
        end
        checks++;
        if (running[0] !== 1'b0) begin
            failures++;
            $display("FAIL stopterm_running got=%b exp=0", running[0]);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stopterm_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int first, nrun;
        first = -1;
        nrun  = 0;
        @(negedge clk);
        start = 2'b11; oneshot = 2'b00; div_val = {4'd3, 4'd1};
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL arst_pre_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (k == 0) start = '0;
        end
        checks++;
        if (running !== 2'b11) begin
            failures++;
            $display("FAIL arst_pre_running got=%b exp=11", running);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 7'd0) begin
            failures++;
            $display("FAIL arst_immediate got=%b exp=%b", obs_vec(), 7'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL arst_post_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (tick && first < 0) first = k;
            if (running !== 2'b00) nrun++;
        end
        checks++;
        if (first !== 5) begin
            failures++;
            $display("FAIL arst_first_tick got=%0d exp=5", first);
        end
        checks++;
        if (nrun !== 0) begin
            failures++;
            $display("FAIL arst_idle got=%0d exp=0", nrun);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_model k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            for (int c = 0; c < NCH; c++) begin
                start[c]              = ($urandom_range(15) == 0);
                stop[c]               = ($urandom_range(11) == 0);
                oneshot[c]            = 1'($urandom_range(1));
                div_val[c*DW +: DW]   = 4'($urandom_range(6));
            end
        end
        start = '0;
        stop  = '0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_restart();
        test_stop_terminal();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

endmodule
